// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch queue entry layout.
package cpu_pkg;

    localparam int PC_W     = 6;
    localparam int INST_W   = 16;
    localparam int QDEPTH   = 2;
    localparam int RESET_PC = 0;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus: program-memory read port, redirect input and decode handshake.
interface inst_fetch_unit_if #(
    parameter int PC_W   = cpu_pkg::PC_W,
    parameter int INST_W = cpu_pkg::INST_W
);
    logic              mem_rd_en;
    logic [PC_W-1:0]   mem_addr;
    logic [INST_W-1:0] mem_rdata;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;

    modport master (
        output mem_rd_en, mem_addr, inst_valid, inst, inst_pc,
        input  mem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, inst_valid, inst, inst_pc,
        output mem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_queue.sv
// Small synchronous FIFO holding fetched {inst, pc} entries; flush clears it in one cycle.
module inst_queue #(
    parameter int W     = 22,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop = i_pop && (r_count != '0);

    // Storage is cleared too so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: issues sequential program-memory reads into a small queue,
// presents the queue head to decode, and flushes/refetches on redirect.
module inst_fetch_unit #(
    parameter int PC_W   = cpu_pkg::PC_W,
    parameter int INST_W = cpu_pkg::INST_W,
    parameter int QDEPTH = cpu_pkg::QDEPTH
) (
    input  logic              clk,
    input  logic              reset,
    inst_fetch_unit_if.master bus
);
    localparam int CW  = $clog2(QDEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam int EW  = INST_W + PC_W;

    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_issued_pc;
    logic            r_inflight;

    logic            w_q_valid;
    logic [EW-1:0]   w_q_data;
    logic [CW-1:0]   w_q_count;
    logic            w_pop;
    logic            w_issue;
    logic [CW1-1:0]  w_committed;
    logic [CW1-1:0]  w_limit;

    assign w_pop = w_q_valid & bus.inst_ready;

    // A read reserves a queue slot at issue so the returning response always fits.
    assign w_committed = {1'b0, w_q_count} + CW1'(r_inflight);
    assign w_limit     = CW1'(QDEPTH) + CW1'(w_pop);
    assign w_issue     = !reset && !bus.redirect_valid && (w_committed < w_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc  <= PC_W'(cpu_pkg::RESET_PC);
            r_issued_pc <= '0;
            r_inflight  <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= bus.redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issued_pc <= r_fetch_pc;
                r_fetch_pc  <= r_fetch_pc + PC_W'(1);
            end
        end
    end

    inst_queue #(
        .W     (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_flush (bus.redirect_valid),
        .i_push  (r_inflight),
        .i_data  ({bus.mem_rdata, r_issued_pc}),
        .i_pop   (w_pop),
        .o_valid (w_q_valid),
        .o_data  (w_q_data),
        .o_count (w_q_count)
    );

    assign bus.mem_rd_en  = w_issue;
    assign bus.mem_addr   = r_fetch_pc;
    assign bus.inst_valid = w_q_valid;
    assign bus.inst       = w_q_data[EW-1:PC_W];
    assign bus.inst_pc    = w_q_data[PC_W-1:0];

endmodule
